// File: rtl/rv32m_pkg.sv
// Shared RV32M execute-stage types: op encodings, multiplier FSM states, datapath width.
package rv32m_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL,
    DONE
  } mul_state_t;

endpackage

// File: rtl/multiplier_if.sv
// Start/done handshake and operand/result bundle between the EX stage and the multiplier.
interface multiplier_if;
  import rv32m_pkg::*;

  logic                     start;
  mul_op_t                  mul_op;
  logic [MUL_WIDTH-1:0]     a;
  logic [MUL_WIDTH-1:0]     b;
  logic [MUL_WIDTH-1:0]     p;
  logic [2*MUL_WIDTH-1:0]   product;
  logic                     busy;
  logic                     done;

  modport master (output start, mul_op, a, b, input p, product, busy, done);
  modport slave  (input start, mul_op, a, b, output p, product, busy, done);

endinterface

// File: rtl/multiplier.sv
// Iterative shift-add RV32M multiplier: magnitudes in, BITS_PER_CYCLE bits per CALC step,
// sign fix-up in FINAL, one-cycle done pulse shared with the divider's handshake.
module multiplier
  import rv32m_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  multiplier_if.slave  mif
);

  localparam int STEPS = MUL_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  mul_state_t               state_q, state_d;
  mul_op_t                  op_q, op_d;
  logic                     neg_q, neg_d;
  logic [MUL_WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*MUL_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MUL_WIDTH-1:0]     p_q, p_d;
  logic [2*MUL_WIDTH-1:0]   product_q, product_d;

  logic                     sign_a, sign_b;
  logic [2*MUL_WIDTH-1:0]   acc_step;
  logic [2*MUL_WIDTH-1:0]   prod_fix;

  // acc holds {partial product high half, remaining multiplier bits}; the 33-bit sum keeps the carry.
  function automatic logic [2*MUL_WIDTH-1:0] add_shift(input logic [2*MUL_WIDTH-1:0] acc,
                                                       input logic [MUL_WIDTH-1:0]   mcand);
    logic [MUL_WIDTH:0] sum;
    sum = {1'b0, acc[2*MUL_WIDTH-1:MUL_WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[MUL_WIDTH-1:1]};
  endfunction

  function automatic logic [MUL_WIDTH-1:0] magnitude(input logic [MUL_WIDTH-1:0] v,
                                                     input logic                 neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    product_d = product_q;
    sign_a    = mif.a[MUL_WIDTH-1] & (mif.mul_op != OP_MULHU);
    sign_b    = mif.b[MUL_WIDTH-1] & ((mif.mul_op == OP_MUL) || (mif.mul_op == OP_MULH));
    acc_step  = acc_q;
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;

    case (state_q)
      IDLE: begin
        if (mif.start) begin
          op_d    = mif.mul_op;
          neg_d   = sign_a ^ sign_b;
          mcand_d = magnitude(mif.a, sign_a);
          acc_d   = {{MUL_WIDTH{1'b0}}, magnitude(mif.b, sign_b)};
          cnt_d   = CNT_W'(STEPS);
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
          acc_step = add_shift(acc_step, mcand_q);
        end
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        product_d = prod_fix;
        p_d       = (op_q == OP_MUL) ? prod_fix[MUL_WIDTH-1:0] : prod_fix[2*MUL_WIDTH-1:MUL_WIDTH];
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      p_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      product_q <= product_d;
    end
  end

  assign mif.busy    = (state_q == CALC) || (state_q == FINAL);
  assign mif.done    = (state_q == DONE);
  assign mif.p       = p_q;
  assign mif.product = product_q;

endmodule
